native_mem_slave: RTL and testbench

- Synthesizable, parametrised memory slave for the picorv32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Provides on-chip word RAM with byte-strobe writes and a programmable number of wait states.
- Adds a small memory-mapped IO window: GPIO out, GPIO in, cycle counter, console byte port.
- Sits directly between the picorv32 core and the rest of the SoC, and is also used as the bench memory.

---
 rtl/native_mem_slave.sv | 151 +++++++++++++++
 tb/tb_native_mem_slave.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/native_mem_slave.sv
// native_mem_slave: picorv32 native-bus slave with word RAM,
// byte-strobe writes, programmable wait states and a 16-byte IO window.
//
// Ports:
//   clk, resetn      - clock (rising edge), async active-low reset
//   mem_valid/instr  - request from core (instr is informational)
//   mem_addr/wdata   - byte address and write data
//   mem_wstrb        - byte write enables, 0 = read
//   mem_ready        - one-cycle completion pulse
//   mem_rdata        - read data, held between completions
//   gpio_out/gpio_in - GPIO output register / input sampled at completion
//   con_valid/data   - console byte strobe and data
//   bus_err          - sticky unmapped-access flag
module native_mem_slave #(
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] IO_BASE     = 32'h1000_0000,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [31:0] gpio_out,
    input  logic [31:0] gpio_in,
    output logic        con_valid,
    output logic [7:0]  con_data,
    output logic        bus_err
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [1:0]  state;
    logic [3:0]  wcnt;
    logic [31:0] a_q;
    logic [31:0] d_q;
    logic [3:0]  s_q;
    logic [31:0] cyc;
    logic [31:0] ram [MEM_WORDS];

    logic [AW-1:0] idx;
    logic          hit_ram;
    logic          hit_io;
    logic          done;
    logic [31:0]   io_rd;
    logic [31:0]   rd_nxt;

    assign idx     = a_q[AW+1:2];
    assign hit_ram = a_q < 32'(MEM_WORDS * 4);
    assign hit_io  = a_q[31:4] == IO_BASE[31:4];
    assign done    = state == S_RESP;

    always_comb begin
        io_rd = 32'd0;
        case (a_q[3:2])
            2'd0:    io_rd = gpio_out;
            2'd1:    io_rd = gpio_in;
            2'd2:    io_rd = cyc;
            default: io_rd = 32'd0;
        endcase
    end

    always_comb begin
        rd_nxt = 32'd0;
        unique case (1'b1)
            hit_ram: rd_nxt = ram[idx];
            hit_io:  rd_nxt = io_rd;
            default: rd_nxt = 32'd0;
        endcase
    end

    // resetn gate: a reset overlapping the completion edge aborts the write
    always_ff @(posedge clk) begin
        if (resetn && done && hit_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (s_q[i]) ram[idx][8*i +: 8] <= d_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            wcnt      <= 4'd0;
            a_q       <= 32'd0;
            d_q       <= 32'd0;
            s_q       <= 4'd0;
            cyc       <= 32'd0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            gpio_out  <= 32'd0;
            con_valid <= 1'b0;
            con_data  <= 8'd0;
            bus_err   <= 1'b0;
        end else begin
            cyc       <= cyc + 32'd1;
            mem_ready <= 1'b0;
            con_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    // mem_ready=1 blocks re-accepting the request just served
                    if (mem_valid && !mem_ready) begin
                        a_q   <= mem_addr;
                        d_q   <= mem_wdata;
                        s_q   <= mem_wstrb;
                        wcnt  <= WS_LOAD;
                        state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wcnt == 4'd0) state <= S_RESP;
                    else              wcnt  <= wcnt - 4'd1;
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    mem_ready <= 1'b1;
                    mem_rdata <= rd_nxt;
                    if (hit_io) begin
                        if (a_q[3:2] == 2'd0) begin
                            for (int i = 0; i < 4; i++) begin
                                if (s_q[i]) gpio_out[8*i +: 8] <= d_q[8*i +: 8];
                            end
                        end
                        if (a_q[3:2] == 2'd3 && s_q[0]) begin
                            con_valid <= 1'b1;
                            con_data  <= d_q[7:0];
                        end
                    end else if (!hit_ram) begin
                        bus_err <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = mem_instr;

endmodule

// File: tb/tb_native_mem_slave.sv
// tb_native_mem_slave: table vectors, hand sequences and a random
// scoreboard run on a zero-wait and a three-wait instance.
module tb_native_mem_slave;
    localparam logic [31:0] IOB = 32'h1000_0000;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    longint tb_cyc = 0;
    always @(posedge clk) tb_cyc++;

    logic [31:0] gpio_in;
    logic        valid [2];
    logic        instr [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];

    logic        rdy0, rdy1, cv0, cv1, be0, be1;
    logic [31:0] rd0, rd1, go0, go1;
    logic [7:0]  cd0, cd1;

    native_mem_slave #(.MEM_WORDS(256), .WAIT_STATES(0),
                       .IO_BASE(IOB), .INIT_FILE("")) u0 (
        .clk(clk), .resetn(resetn),
        .mem_valid(valid[0]), .mem_instr(instr[0]),
        .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
        .mem_ready(rdy0), .mem_rdata(rd0),
        .gpio_out(go0), .gpio_in(gpio_in),
        .con_valid(cv0), .con_data(cd0), .bus_err(be0)
    );

    native_mem_slave #(.MEM_WORDS(256), .WAIT_STATES(3),
                       .IO_BASE(IOB), .INIT_FILE("")) u3 (
        .clk(clk), .resetn(resetn),
        .mem_valid(valid[1]), .mem_instr(instr[1]),
        .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
        .mem_ready(rdy1), .mem_rdata(rd1),
        .gpio_out(go1), .gpio_in(gpio_in),
        .con_valid(cv1), .con_data(cd1), .bus_err(be1)
    );

    function automatic logic f_rdy(int d); return d == 0 ? rdy0 : rdy1; endfunction
    function automatic logic f_cv(int d); return d == 0 ? cv0 : cv1; endfunction
    function automatic logic f_be(int d); return d == 0 ? be0 : be1; endfunction
    function automatic logic [31:0] f_rd(int d); return d == 0 ? rd0 : rd1; endfunction
    function automatic logic [31:0] f_go(int d); return d == 0 ? go0 : go1; endfunction
    function automatic logic [7:0] f_cd(int d); return d == 0 ? cd0 : cd1; endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // one bus transaction; checks latency, pulse width, data hold
    // and that no second completion follows
    task automatic xfer(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input bit scr,
                        output logic [31:0] rd, output logic c_v,
                        output logic [7:0] c_d, output longint t);
        int lat;
        bit seen;
        bit extra;
        int ws_n;
        ws_n = (d == 0) ? 0 : 3;
        @(negedge clk);
        valid[d] = 1'b1;
        instr[d] = 1'($urandom);
        addr[d]  = a;
        wdata[d] = wd;
        wstrb[d] = ws;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (f_rdy(d)) seen = 1;
            else if (scr) begin
                addr[d]  = $urandom;
                wdata[d] = $urandom;
                wstrb[d] = 4'($urandom);
            end
        end
        chk($sformatf("latency d%0d a=%h", d, a), 32'(lat), 32'(ws_n + 2));
        rd  = f_rd(d);
        c_v = f_cv(d);
        c_d = f_cd(d);
        t   = tb_cyc;
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
        wstrb[d] = 4'd0;
        chk("ready_pulse_width", 32'(f_rdy(d)), 32'd0);
        chk("con_valid_width", 32'(f_cv(d)), 32'd0);
        chk("rdata_hold", f_rd(d), rd);
        extra = 0;
        repeat (ws_n + 2) begin
            @(posedge clk);
            #1;
            if (f_rdy(d)) extra = 1;
        end
        chk("no_extra_ready", 32'(extra), 32'd0);
    endtask

    // reference model: RAM words, GPIO register, sticky error
    logic [31:0] ref_ram [2][256];
    logic [31:0] gm [2];
    logic        bm [2];

    task automatic model(input int d, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, output logic [31:0] exp);
        logic [31:0] w;
        exp = 32'd0;
        if (a < 32'd1024) begin
            w   = ref_ram[d][a[9:2]];
            exp = w;
            for (int i = 0; i < 4; i++) if (ws[i]) w[8*i +: 8] = wd[8*i +: 8];
            ref_ram[d][a[9:2]] = w;
        end else if (a >= IOB && a < IOB + 32'd16) begin
            if (a - IOB < 32'd4) begin
                exp = gm[d];
                for (int i = 0; i < 4; i++) if (ws[i]) gm[d][8*i +: 8] = wd[8*i +: 8];
            end else if (a - IOB < 32'd8) begin
                exp = gpio_in;
            end
        end else begin
            bm[d] = 1'b1;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [31:0] exp;
        bit          chk_rd;
        logic [31:0] exp_gpio;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv[$];
        logic [31:0] r, r2, e;
        logic        c_v;
        logic [7:0]  c_d;
        longint      t, t2;
        bit          bad;

        for (int d = 0; d < 2; d++) begin
            valid[d] = 0; instr[d] = 0; addr[d] = 0; wdata[d] = 0; wstrb[d] = 0;
            gm[d] = 0; bm[d] = 0;
        end
        gpio_in = 32'hCAFE_0001;

        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst ready d%0d", d), 32'(f_rdy(d)), 32'd0);
            chk($sformatf("rst rdata d%0d", d), f_rd(d), 32'd0);
            chk($sformatf("rst gpio d%0d", d), f_go(d), 32'd0);
            chk($sformatf("rst con_valid d%0d", d), 32'(f_cv(d)), 32'd0);
            chk($sformatf("rst con_data d%0d", d), 32'(f_cd(d)), 32'd0);
            chk($sformatf("rst bus_err d%0d", d), 32'(f_be(d)), 32'd0);
        end
        @(negedge clk);
        resetn = 1'b1;

        tv.push_back('{32'h0,       32'h3fc0_0093, 4'hF, 32'h0,         0, 32'h0});
        tv.push_back('{32'h0,       32'h0,         4'h0, 32'h3fc0_0093, 1, 32'h0});
        tv.push_back('{32'h20,      32'h1122_3344, 4'hF, 32'h0,         0, 32'h0});
        tv.push_back('{32'h20,      32'hAABB_CCDD, 4'h5, 32'h1122_3344, 1, 32'h0});
        tv.push_back('{32'h20,      32'h0,         4'h0, 32'h11BB_33DD, 1, 32'h0});
        tv.push_back('{32'h23,      32'h0,         4'h0, 32'h11BB_33DD, 1, 32'h0});
        tv.push_back('{IOB,         32'h5A,        4'hF, 32'h0,         1, 32'h5A});
        tv.push_back('{IOB,         32'h0,         4'h0, 32'h5A,        1, 32'h5A});
        tv.push_back('{IOB + 4,     32'hFFFF,      4'hF, 32'hCAFE_0001, 1, 32'h5A});
        tv.push_back('{IOB,         32'h1234_5600, 4'h2, 32'h5A,        1, 32'h565A});
        tv.push_back('{IOB + 32'hC, 32'h0,         4'h0, 32'h0,         1, 32'h565A});
        tv.push_back('{32'h3FC,     32'h0000_0007, 4'hF, 32'h0,         0, 32'h565A});
        tv.push_back('{32'h3FC,     32'h0,         4'h0, 32'h7,         1, 32'h565A});

        foreach (tv[i]) begin
            xfer(0, tv[i].a, tv[i].wd, tv[i].ws, 0, r, c_v, c_d, t);
            if (tv[i].chk_rd) chk($sformatf("vec%0d rdata", i), r, tv[i].exp);
            chk($sformatf("vec%0d gpio_out", i), go0, tv[i].exp_gpio);
        end

        xfer(0, IOB + 32'hC, 32'h41, 4'h1, 0, r, c_v, c_d, t);
        chk("con pulse", 32'(c_v), 32'd1);
        chk("con data", 32'(c_d), 32'h41);
        xfer(0, IOB + 32'hC, 32'h99, 4'h2, 0, r, c_v, c_d, t);
        chk("con no-strobe", 32'(c_v), 32'd0);
        chk("con data kept", 32'(c_d), 32'h41);

        xfer(0, IOB + 8, 0, 0, 0, r, c_v, c_d, t);
        repeat (13) @(posedge clk);
        xfer(0, IOB + 8, 0, 0, 0, r2, c_v, c_d, t2);
        chk("cycle counter delta", r2 - r, 32'(t2 - t));

        chk("bus_err before", 32'(be0), 32'd0);
        xfer(0, 32'h2000_0000, 0, 0, 0, r, c_v, c_d, t);
        chk("unmapped rdata", r, 32'd0);
        chk("unmapped bus_err", 32'(be0), 32'd1);
        xfer(0, 32'h2000_0004, 32'hFFFF_FFFF, 4'hF, 0, r, c_v, c_d, t);
        xfer(0, 32'h0, 0, 0, 0, r, c_v, c_d, t);
        chk("good read after err", r, 32'h3fc0_0093);
        chk("bus_err sticky", 32'(be0), 32'd1);

        xfer(1, 32'h10, 32'h0BAD_F00D, 4'hF, 0, r, c_v, c_d, t);
        xfer(1, 32'h10, 0, 0, 1, r, c_v, c_d, t);
        chk("ws3 read, addr scrambled", r, 32'h0BAD_F00D);
        ref_ram[1][4] = 32'h0BAD_F00D;

        for (int w = 0; w < 64; w++) begin
            if (w == 4) continue;
            e = $urandom;
            xfer(1, 32'(w * 4), e, 4'hF, 0, r, c_v, c_d, t);
            ref_ram[1][w] = e;
        end

        for (int k = 0; k < 80; k++) begin
            int sel;
            logic [31:0] a, wd;
            logic [3:0]  ws;
            sel = $urandom_range(0, 9);
            wd  = $urandom;
            ws  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            gpio_in = $urandom;
            if (sel < 7)      a = {22'd0, 6'($urandom_range(0, 63)), 2'($urandom), 2'b00} >> 2;
            else if (sel < 9) a = IOB + 32'($urandom_range(0, 1) * 4);
            else              a = 32'h3000_0000 + 32'($urandom_range(0, 255));
            if (sel < 7) a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom)};
            model(1, a, wd, ws, e);
            xfer(1, a, wd, ws, 0, r, c_v, c_d, t);
            chk($sformatf("rand%0d rdata a=%h", k, a), r, e);
            chk($sformatf("rand%0d gpio", k), go1, gm[1]);
            chk($sformatf("rand%0d bus_err", k), 32'(be1), 32'(bm[1]));
        end

        @(negedge clk);
        valid[1] = 1'b1;
        addr[1]  = 32'h0;
        wdata[1] = 32'hDEAD_BEEF;
        wstrb[1] = 4'hF;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        resetn   = 1'b0;
        valid[1] = 1'b0;
        wstrb[1] = 4'h0;
        bad = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (rdy1) bad = 1;
        end
        chk("no ready after abort", 32'(bad), 32'd0);
        chk("bus_err cleared by reset", 32'(be0), 32'd0);
        chk("gpio cleared by reset", go1, 32'd0);
        gm[0] = 0; gm[1] = 0; bm[0] = 0; bm[1] = 0;
        @(negedge clk);
        resetn = 1'b1;
        xfer(1, 32'h0, 0, 0, 0, r, c_v, c_d, t);
        chk("word0 unchanged by aborted write", r, ref_ram[1][0]);

        e = 32'd0;
        for (int k = 0; k < 6; k++) begin
            xfer(1, 32'd1020, e, 4'hF, 0, r, c_v, c_d, t);
            xfer(1, 32'd1020, 0, 4'h0, 0, r, c_v, c_d, t);
            chk($sformatf("loop word255 iter%0d", k), r, 32'(k));
            e = r + 32'd1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
